fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: CACHE_LINE_WIDTH, default 64, cacheline size in bytes (power of two).
REQ-002 Parameter: STALE_CNT_W, default 2, width of the stale-response counter.
REQ-003 clk_in  input  1  sole clock; all state updates on posedge.
REQ-004 rst_N_in  input  1  reset; asynchronous, active-low.
REQ-005 flush_in  input  1  misprediction flush; kills all in-flight fetch work.
REQ-006 bp_pc_valid  input  1  branch predictor offers a predicted PC.
REQ-007 bp_pc  input  64  predicted PC.
REQ-008 l0_hit  input  1  L0 holds bp_pc's line; qualified by bp_pc_valid, same cycle.
REQ-009 bp_ready  output  1  sequencer accepts bp_pc this cycle (combinational).
REQ-010 l1i_req_valid  output  1  L1I line request pending.
REQ-011 l1i_req_addr  output  64  line-aligned request address.
REQ-012 l1i_req_ready  input  1  L1I accepts request.
REQ-013 l1i_resp_valid  input  1  L1I returns a line (in request order).
REQ-014 fetch_ready  input  1  fetch stage can take a PC.
REQ-015 fetch_pc_valid  output  1  registered; fetch_pc and fetch_src_l1i valid.
REQ-016 fetch_pc  output  64  PC handed to fetch.
REQ-017 fetch_src_l1i  output  1  1 = line comes from L1I response, 0 = from L0.
REQ-018 busy  output  1  state != IDLE or stale counter nonzero.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT; state and all registered outputs SHALL be held in registers.
REQ-020 bp_ready SHALL be 1 only when state==IDLE, flush_in==0, stale counter not saturated, and (fetch_pc_valid==0 or fetch_ready==1).
REQ-021 Accept (bp_pc_valid & bp_ready) with l0_hit=1: next cycle fetch_pc_valid=1, fetch_pc=bp_pc, fetch_src_l1i=0; state stays IDLE; one accept per cycle sustained.
REQ-022 Accept with l0_hit=0: latch bp_pc, state->REQ; fetch_pc_valid deasserts next cycle if fetch_ready consumed it.
REQ-023 REQ: l1i_req_valid=1, l1i_req_addr = latched PC with low $clog2(CACHE_LINE_WIDTH) bits zeroed, stable until l1i_req_ready; on l1i_req_ready state->WAIT.
REQ-024 WAIT: on l1i_resp_valid with stale counter==0, next cycle fetch_pc_valid=1, fetch_pc=latched PC, fetch_src_l1i=1; state->IDLE.
REQ-025 fetch_pc_valid/fetch_pc/fetch_src_l1i SHALL hold stable until fetch_ready; fetch_ready with fetch_pc_valid=1 and no new delivery clears fetch_pc_valid next cycle.
REQ-026 l1i_resp_valid while stale counter>0 SHALL be dropped and decrement the counter (any state); it never completes a WAIT.
REQ-027 flush_in SHALL, next cycle: state->IDLE, fetch_pc_valid=0, l1i_req_valid=0.
REQ-028 Flush in WAIT, or in REQ with l1i_req_ready=1 same cycle, SHALL increment the stale counter (saturating at 2^STALE_CNT_W-1).
REQ-029 Flush with l1i_resp_valid same cycle: response dropped; counter unchanged if state was WAIT with counter==0 (response was the outstanding one); otherwise per REQ-026/REQ-028 net effect.
REQ-030 Flush in REQ without l1i_req_ready: request withdrawn, counter unchanged.
REQ-031 bp_pc_valid during flush cycle SHALL be ignored (bp_ready=0).
REQ-032 l1i_resp_valid in IDLE/REQ with counter==0 is a protocol error; it SHALL be ignored.

Reset
REQ-033 rst_N_in low SHALL asynchronously force state=IDLE, stale counter=0, fetch_pc_valid=0, fetch_pc=0, fetch_src_l1i=0, l1i_req_valid=0, latched PC=0, busy=0; bp_ready=0 while in reset.
REQ-034 Reset asserted mid-WAIT SHALL clear state with no stale tracking; first bp_pc after release accepted normally.

Verification
REQ-035 L0 stream: bp_pc 0x1000,0x1010,0x1020 with l0_hit=1, fetch_ready=1 -> fetch_pc 0x1000,0x1010,0x1020 on consecutive cycles, src=0, no l1i_req_valid.
REQ-036 Miss: bp_pc 0x2044 l0_hit=0 -> l1i_req_addr=0x2040; hold l1i_req_ready=0 3 cycles (addr stable); ready, resp 2 cycles later -> fetch_pc=0x2044 src=1 next cycle.
REQ-037 Flush in WAIT: miss 0x3000, flush, then miss 0x4008; first resp dropped, second resp -> fetch_pc=0x4008 only.
REQ-038 Backpressure: fetch_ready=0 with fetch_pc_valid=1 for 4 cycles -> bp_ready=0, outputs stable; fetch_ready=1 -> accept resumes.
REQ-039 Saturation: 3 flushes each in WAIT, no responses -> counter=3, bp_ready=0; three responses -> counter=0, bp_ready=1.
REQ-040 Async reset asserted mid-REQ between clock edges -> l1i_req_valid=0 immediately, busy=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - hands predicted PCs to fetch, sourcing lines from L0 or an L1I request
//
// Purpose:
//   Takes predicted PCs from the branch predictor. An L0 hit goes straight to
//   fetch on the next cycle. An L0 miss goes through IDLE -> REQ -> WAIT: one
//   line-aligned L1I request is issued, and the PC is delivered when its
//   response returns. A flush abandons all in-flight work. Any L1I request
//   that has been accepted but not yet answered is counted in a saturating
//   stale counter, so its late response is dropped.
//
// Ports:
//   clk_in, rst_N_in        clock, asynchronous active-low reset
//   flush_in                misprediction flush
//   bp_pc_valid/bp_pc       predicted PC offer
//   l0_hit                  L0 holds bp_pc's line (same cycle as bp_pc_valid)
//   bp_ready                offer accepted this cycle (combinational)
//   l1i_req_valid/addr      line request to L1I; l1i_req_ready accepts it
//   l1i_resp_valid          L1I line return, in request order
//   fetch_ready             fetch stage can take a PC
//   fetch_pc_valid/fetch_pc/fetch_src_l1i  registered PC handed to fetch
//   busy                    miss in progress or stale responses outstanding

module fetch_sequencer #(
    parameter int CACHE_LINE_WIDTH = 64,
    parameter int STALE_CNT_W      = 2
) (
    input  logic        clk_in,
    input  logic        rst_N_in,
    input  logic        flush_in,
    input  logic        bp_pc_valid,
    input  logic [63:0] bp_pc,
    input  logic        l0_hit,
    output logic        bp_ready,
    output logic        l1i_req_valid,
    output logic [63:0] l1i_req_addr,
    input  logic        l1i_req_ready,
    input  logic        l1i_resp_valid,
    input  logic        fetch_ready,
    output logic        fetch_pc_valid,
    output logic [63:0] fetch_pc,
    output logic        fetch_src_l1i,
    output logic        busy
);

    localparam int                     LINE_OFF_W = $clog2(CACHE_LINE_WIDTH);
    localparam logic [63:0]            LINE_MASK  = ~((64'd1 << LINE_OFF_W) - 64'd1);
    localparam logic [STALE_CNT_W-1:0] STALE_MAX  = '1;
    localparam logic [STALE_CNT_W-1:0] STALE_ONE  = STALE_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                 state;
    logic [STALE_CNT_W-1:0] stale_cnt;
    logic [63:0]            miss_pc;

    logic                   out_free;
    logic                   accept_hit;
    logic                   accept_miss;
    logic                   live_resp;
    logic                   stale_inc;
    logic                   stale_dec;
    logic [STALE_CNT_W-1:0] stale_next;

    // The output slot can take a new PC if it is empty or is being consumed now.
    assign out_free = !fetch_pc_valid || fetch_ready;

    // Qualify with rst_N_in so that no offer appears accepted while reset is held.
    assign bp_ready = rst_N_in && (state == IDLE) && !flush_in &&
                      (stale_cnt != STALE_MAX) && out_free;

    assign accept_hit  = bp_pc_valid && bp_ready && l0_hit;
    assign accept_miss = bp_pc_valid && bp_ready && !l0_hit;

    // A response belongs to the current miss only after every stale response
    // has drained.
    assign live_resp = l1i_resp_valid && (state == WAIT) && (stale_cnt == '0);

    // A flush orphans the outstanding request when L1I has it or is taking it
    // this cycle. The exception is when that request's own response arrives
    // in the flush cycle: the request then leaves nothing behind.
    assign stale_inc = flush_in &&
                       ((state == WAIT) || ((state == REQ) && l1i_req_ready)) &&
                       !live_resp;

    // Any response seen while stale responses are pending is one of them.
    assign stale_dec = l1i_resp_valid && (stale_cnt != '0);

    always_comb begin
        stale_next = stale_cnt;
        if (stale_inc && !stale_dec) begin
            if (stale_cnt != STALE_MAX) begin
                stale_next = stale_cnt + STALE_ONE;
            end
        end else if (stale_dec && !stale_inc) begin
            stale_next = stale_cnt - STALE_ONE;
        end
    end

    assign l1i_req_addr = miss_pc & LINE_MASK;
    assign busy         = (state != IDLE) || (stale_cnt != '0);

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state          <= IDLE;
            stale_cnt      <= '0;
            miss_pc        <= '0;
            l1i_req_valid  <= 1'b0;
            fetch_pc_valid <= 1'b0;
            fetch_pc       <= '0;
            fetch_src_l1i  <= 1'b0;
        end else begin
            stale_cnt <= stale_next;

            if (flush_in) begin
                state          <= IDLE;
                l1i_req_valid  <= 1'b0;
                fetch_pc_valid <= 1'b0;
            end else begin
                // Output slot: a new delivery wins over consumption.
                if (accept_hit) begin
                    fetch_pc_valid <= 1'b1;
                    fetch_pc       <= bp_pc;
                    fetch_src_l1i  <= 1'b0;
                end else if (live_resp) begin
                    fetch_pc_valid <= 1'b1;
                    fetch_pc       <= miss_pc;
                    fetch_src_l1i  <= 1'b1;
                end else if (fetch_ready) begin
                    fetch_pc_valid <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (accept_miss) begin
                            miss_pc       <= bp_pc;
                            l1i_req_valid <= 1'b1;
                            state         <= REQ;
                        end
                    end
                    REQ: begin
                        if (l1i_req_ready) begin
                            l1i_req_valid <= 1'b0;
                            state         <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (live_resp) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        l1i_req_valid <= 1'b0;
                        state         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
